// File: rtl/cva6_fifo_pop_stage_pkg.sv
// Purpose: shared types and helpers for the FIFO pop stage (counter type, occupancy update).
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   CNT_W             width of the buffered-entry counter (covers BUF_DEPTH up to 3)
//   MAX_READ_LATENCY  largest supported upstream read latency
//   cnt_t             counter type
//   cnt_next()        counter update: +1 on capture, -1 on handshake
package cva6_fifo_pop_stage_pkg;

    localparam int unsigned CNT_W            = 2;
    localparam int unsigned MAX_READ_LATENCY = 1;

    typedef logic [CNT_W-1:0] cnt_t;

    // Capture and handshake in the same cycle cancel out. The pop rule
    // never lets a capture land while the buffer is full, so no saturation
    // is needed here.
    function automatic cnt_t cnt_next(input cnt_t cnt, input logic inc, input logic dec);
        return cnt + cnt_t'(inc) - cnt_t'(dec);
    endfunction

endpackage

// File: rtl/cva6_fifo_pop_stage.sv
// Purpose: registered pop-side stage draining a cva6_fifo_v3 into a valid/ready stream.
// Latency: pop in cycle t -> valid_o in t+1+READ_LATENCY; one item per cycle sustained.
// Backpressure: pops stop once buffered + in-flight entries fill BUF_DEPTH; no path from ready_i to fifo_pop_o.
//
// Ports:
//   clk_i, rst_i    clock; synchronous active-high reset (clears buffer contents too)
//   flush_i         drop buffered and in-flight data; suppresses popping this cycle
//   fifo_empty_i    upstream FIFO empty_o
//   fifo_data_i     upstream FIFO data_o (valid with pop for latency 0, one cycle later for latency 1)
//   fifo_pop_o      upstream FIFO pop_i
//   valid_o/ready_i output handshake; data_o is the ring-buffer head
//   count_o         entries currently held in the ring buffer
//
// READ_LATENCY must be 0 or 1. BUF_DEPTH is derived and must not be overridden.
module cva6_fifo_pop_stage
    import cva6_fifo_pop_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned BUF_DEPTH    = READ_LATENCY + 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       flush_i,
    input  logic       fifo_empty_i,
    input  dtype       fifo_data_i,
    output logic       fifo_pop_o,
    output logic       valid_o,
    input  logic       ready_i,
    output dtype       data_o,
    output logic [1:0] count_o
);

    localparam int unsigned        PTR_W     = (BUF_DEPTH > 2) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W:0]     OCC_LIMIT = (CNT_W+1)'(BUF_DEPTH);

    dtype             buf_q [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    cnt_t             cnt_q;
    logic             inflight_q;

    logic             capture;
    logic             handshake;
    logic [CNT_W:0]   occupancy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Entries already stored plus the read still travelling through the
    // FIFO's output register: a new pop is only safe if both fit.
    assign occupancy = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inflight_q};

    // Reset is included so no pop leaks out while rst_i is held, even though
    // the registered state it would otherwise rely on is still being cleared.
    assign fifo_pop_o = ~rst_i & ~fifo_empty_i & ~flush_i & (occupancy < OCC_LIMIT);

    assign valid_o   = (cnt_q != '0);
    assign data_o    = buf_q[rd_ptr_q];
    assign count_o   = cnt_q;
    assign handshake = valid_o & ready_i;

    if (READ_LATENCY == 0) begin : g_comb_read
        // Data is on fifo_data_i in the pop cycle itself.
        assign inflight_q = 1'b0;
        assign capture    = fifo_pop_o;
    end else begin : g_sync_read
        // Data returns one cycle after the pop; track that outstanding read.
        always_ff @(posedge clk_i) begin
            if (rst_i || flush_i) begin
                inflight_q <= 1'b0;
            end else begin
                inflight_q <= fifo_pop_o;
            end
        end
        assign capture = inflight_q;
    end

    // Flush wins over a same-cycle capture (the returning read is dropped)
    // and over a same-cycle handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (capture) begin
                buf_q[wr_ptr_q] <= fifo_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (handshake) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_next(cnt_q, capture, handshake);
        end
    end

endmodule
